// File: rtl/mux_arb_reg.sv
// NUM_IN:1 handshaked mux with a registered output stage; direct-select or round-robin grant.
// Optional stall counter output enabled by defining MUX_ARB_STALL_CNT_EN.
module mux_arb_reg #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst_f,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    mode,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
`ifdef MUX_ARB_STALL_CNT_EN
    output logic [15:0]             stall_cnt,
`endif
    output logic [SEL_W-1:0]        out_src
);

    logic [WIDTH-1:0] chan [NUM_IN];
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] out_src_q, out_src_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0] g;
    logic             grant;
    logic             load_en;

    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            chan[i] = in_data[i*WIDTH +: WIDTH];
        end
    end

    assign load_en = rst_f & (~out_valid_q | out_ready);

    // Round-robin search starts at rr_ptr and wraps; the first valid channel wins.
    always_comb begin
        int unsigned      k;
        logic [SEL_W-1:0] idx;
        grant = 1'b0;
        g     = '0;
        k     = 0;
        idx   = '0;
        if (!mode) begin
            if ({1'b0, sel} < (SEL_W+1)'(NUM_IN)) begin
                grant = in_valid[sel];
                g     = sel;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                k = 32'(rr_ptr_q) + i;
                if (k >= NUM_IN) begin
                    k = k - NUM_IN;
                end
                idx = SEL_W'(k);
                if (!grant && in_valid[idx]) begin
                    grant = 1'b1;
                    g     = idx;
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (load_en && grant) begin
            in_ready[g] = 1'b1;
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_src_d   = out_src_q;
        rr_ptr_d    = rr_ptr_q;
        if (load_en) begin
            if (grant) begin
                out_data_d  = chan[g];
                out_src_d   = g;
                out_valid_d = 1'b1;
                if (mode) begin
                    rr_ptr_d = (g == SEL_W'(NUM_IN - 1)) ? '0 : g + 1'b1;
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_f) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_src_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_src_q   <= out_src_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_src   = out_src_q;

`ifdef MUX_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && !out_ready && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_f) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mux_arb_reg.sv
// Directed, table-driven bench for mux_arb_reg (4 channels x 32 bits).
module tb_mux_arb_reg;

    logic         clk = 1'b0;
    logic         rst_f = 1'b0;
    logic [127:0] in_data = '0;
    logic [3:0]   in_valid = '0;
    logic [3:0]   in_ready;
    logic [1:0]   sel = '0;
    logic         mode = 1'b0;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [1:0]   out_src;
`ifdef MUX_ARB_STALL_CNT_EN
    logic [15:0]  stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    localparam logic [127:0] DRR = {32'd4, 32'd3, 32'd2, 32'd1};
    localparam logic [127:0] DDB = {32'd4, 32'hDEADBEEF, 32'd2, 32'd1};

    mux_arb_reg #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) dut (
        .clk      (clk),
        .rst_f    (rst_f),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sel      (sel),
        .mode     (mode),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
`ifdef MUX_ARB_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .out_src  (out_src)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst_f;
        logic         mode;
        logic [1:0]   sel;
        logic [3:0]   valid;
        logic [127:0] data;
        logic         ordy;
        logic [3:0]   exp_rdy;
        logic         exp_ov;
        logic [31:0]  exp_od;
        logic [1:0]   exp_src;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input logic r, input logic m, input logic [1:0] s,
                                input logic [3:0] v, input logic [127:0] d, input logic o,
                                input logic [3:0] er, input logic eov, input logic [31:0] eod,
                                input logic [1:0] es);
        vec_t t;
        t.rst_f = r; t.mode = m; t.sel = s; t.valid = v; t.data = d; t.ordy = o;
        t.exp_rdy = er; t.exp_ov = eov; t.exp_od = eod; t.exp_src = es;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic m, input logic [1:0] s, input logic [3:0] v,
                         input logic [127:0] d, input logic o);
        @(negedge clk);
        rst_f = r; mode = m; sel = s; in_valid = v; in_data = d; out_ready = o;
        #1;
    endtask

    task automatic post_edge(input string tag, input logic eov, input logic [31:0] eod,
                             input logic [1:0] es);
        @(posedge clk);
        #1;
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(eov));
        chk({tag, ".out_data"}, out_data, eod);
        chk({tag, ".out_src"}, 32'(out_src), 32'(es));
    endtask

    initial begin
        // Reset with all requests asserted, then direct mode.
        vecs[0]  = mk(0, 0, 0, 4'b1111, DRR, 1, 4'b0000, 0, 32'd0, 0);
        vecs[1]  = mk(0, 0, 0, 4'b1111, DRR, 1, 4'b0000, 0, 32'd0, 0);
        vecs[2]  = mk(1, 0, 0, 4'b1111, DRR, 1, 4'b0001, 1, 32'd1, 0);
        vecs[3]  = mk(1, 0, 2, 4'b0100, DDB, 1, 4'b0100, 1, 32'hDEADBEEF, 2);
        vecs[4]  = mk(1, 0, 3, 4'b0100, DDB, 1, 4'b0000, 0, 32'hDEADBEEF, 2);
        vecs[5]  = mk(1, 0, 3, 4'b1000, DDB, 0, 4'b1000, 1, 32'd4, 3);
        vecs[6]  = mk(1, 0, 3, 4'b1000, DDB, 0, 4'b0000, 1, 32'd4, 3);
        vecs[7]  = mk(1, 0, 3, 4'b0000, DDB, 1, 4'b0000, 0, 32'd4, 3);
        // Round-robin fairness: 0,1,2,3,0,1.
        vecs[8]  = mk(1, 1, 0, 4'b1111, DRR, 1, 4'b0001, 1, 32'd1, 0);
        vecs[9]  = mk(1, 1, 0, 4'b1111, DRR, 1, 4'b0010, 1, 32'd2, 1);
        vecs[10] = mk(1, 1, 0, 4'b1111, DRR, 1, 4'b0100, 1, 32'd3, 2);
        vecs[11] = mk(1, 1, 0, 4'b1111, DRR, 1, 4'b1000, 1, 32'd4, 3);
        vecs[12] = mk(1, 1, 0, 4'b1111, DRR, 1, 4'b0001, 1, 32'd1, 0);
        vecs[13] = mk(1, 1, 0, 4'b1111, DRR, 1, 4'b0010, 1, 32'd2, 1);
        // Skip and wrap: rr_ptr=3 with only ch1, then rr_ptr=2 with only ch0.
        vecs[14] = mk(1, 1, 0, 4'b0100, DRR, 1, 4'b0100, 1, 32'd3, 2);
        vecs[15] = mk(1, 1, 0, 4'b0010, DRR, 1, 4'b0010, 1, 32'd2, 1);
        vecs[16] = mk(1, 1, 0, 4'b0001, DRR, 1, 4'b0001, 1, 32'd1, 0);
        vecs[17] = mk(1, 1, 0, 4'b0000, DRR, 1, 4'b0000, 0, 32'd1, 0);
        // Direct grant must leave rr_ptr (=1) untouched.
        vecs[18] = mk(1, 0, 1, 4'b1111, DRR, 1, 4'b0010, 1, 32'd2, 1);
        vecs[19] = mk(1, 1, 0, 4'b1111, DRR, 1, 4'b0010, 1, 32'd2, 1);

        for (int i = 0; i < 20; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            drive(vecs[i].rst_f, vecs[i].mode, vecs[i].sel, vecs[i].valid, vecs[i].data,
                  vecs[i].ordy);
            chk({tag, ".in_ready"}, 32'(in_ready), 32'(vecs[i].exp_rdy));
            post_edge(tag, vecs[i].exp_ov, vecs[i].exp_od, vecs[i].exp_src);
        end

        // Backpressure: hold item 5 for 5 cycles while ch0 offers 6.
        drive(0, 1, 0, 4'b0000, '0, 1);
        post_edge("bp.rst", 0, 32'd0, 0);
        drive(1, 1, 0, 4'b0001, {96'd0, 32'd5}, 1);
        chk("bp.load.in_ready", 32'(in_ready), 32'h1);
        post_edge("bp.load", 1, 32'd5, 0);
        for (int c = 0; c < 5; c++) begin
            drive(1, 1, 0, 4'b0001, {96'd0, 32'd6}, 0);
            chk($sformatf("bp.hold%0d.in_ready", c), 32'(in_ready), 32'h0);
            post_edge($sformatf("bp.hold%0d", c), 1, 32'd5, 0);
        end
`ifdef MUX_ARB_STALL_CNT_EN
        chk("bp.stall_cnt", 32'(stall_cnt), 32'd5);
`endif
        drive(1, 1, 0, 4'b0001, {96'd0, 32'd6}, 1);
        chk("bp.release.in_ready", 32'(in_ready), 32'h1);
        post_edge("bp.release", 1, 32'd6, 0);

        // Mid-operation reset while stalled; rr_ptr is 1 beforehand.
        drive(1, 1, 0, 4'b0010, {64'd0, 32'd7, 32'd0}, 0);
        post_edge("mr.stall", 1, 32'd6, 0);
        drive(0, 1, 0, 4'b0010, {64'd0, 32'd7, 32'd0}, 0);
        chk("mr.rst.in_ready", 32'(in_ready), 32'h0);
        post_edge("mr.rst", 0, 32'd0, 0);
`ifdef MUX_ARB_STALL_CNT_EN
        chk("mr.stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        drive(1, 1, 0, 4'b1111, DRR, 1);
        chk("mr.after.in_ready", 32'(in_ready), 32'h1);
        post_edge("mr.after", 1, 32'd1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/mux_arb_reg.md
Name: mux_arb_reg

Overview:
- Parametrised successor to the 4:1 32-bit datapath mux.
- Provides NUM_IN channels of WIDTH bits with per-channel valid/ready handshakes and a registered output stage, so upstream sources are decoupled from the consumer.
- Two select modes:
  - direct: an external select picks the channel, as in the existing mux.
  - round-robin: fair arbitration between channels.
- Used in the SISC datapath wherever several producers share one consumer, for example register-file write-back sources.

Parameters:
- WIDTH, 32: data width per channel.
- NUM_IN, 4: number of input channels, 2..16.
- SEL_W, 2: select/source-index width; NUM_IN <= 2**SEL_W is required.

Ports:
- clk  in  1  system clock, rising edge.
- rst_f  in  1  reset, synchronous, active-low.
- in_data  in  NUM_IN*WIDTH  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  in  NUM_IN  per-channel data valid.
- in_ready  out  NUM_IN  per-channel accept, combinational.
- sel  in  SEL_W  channel index used in direct mode.
- mode  in  1  0 = direct (sel), 1 = round-robin.
- out_data  out  WIDTH  registered selected data.
- out_valid  out  1  out_data holds an item.
- out_ready  in  1  consumer accepts the item.
- out_src  out  SEL_W  index of the channel that supplied out_data.

Behaviour:
- Reset: synchronous on rising clk while rst_f=0.
  - out_valid=0, out_data=0, out_src=0, rr_ptr=0.
  - in_ready is all 0 while rst_f=0.
  - Any item in flight is discarded.
- Storage is a single output register. Latency is 1 cycle from input handshake to out_valid.
- load_en = rst_f & (!out_valid | out_ready).
- Grant g is computed combinationally:
  - mode=0: grant only if sel < NUM_IN and in_valid[sel]=1; then g=sel. If sel >= NUM_IN, there is no grant and in_ready is all 0.
  - mode=1: g is the first k with in_valid[k]=1, searching rr_ptr, rr_ptr+1, ... and wrapping modulo NUM_IN. There is no grant if in_valid is all 0.
- in_ready[g] = load_en & grant. All other in_ready bits are 0. At most one in_ready bit is high in any cycle.
- On a clock edge with load_en & grant: out_data <= channel g, out_src <= g, out_valid <= 1.
- On a clock edge with load_en & !grant: out_valid <= 0. out_data and out_src keep their values.
- While out_valid=1 and out_ready=0: out_data, out_src and out_valid hold stable, and in_ready is all 0.
- Simultaneous out_ready and new grant in the same cycle: the old item leaves and the new item loads. This sustains 1 item per cycle.
- rr_ptr updates only on a grant in mode=1: rr_ptr <= (g == NUM_IN-1) ? 0 : g+1. It is unchanged in mode=0.
- mode and sel are sampled every cycle. A change takes effect on the next grant and never disturbs a held item.
- in_valid is not required to stay asserted until accepted. A dropped request simply loses arbitration.

Optional Feature:
- Macro: MUX_ARB_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt [15:0].
  - stall_cnt increments on each cycle with out_valid=1 and out_ready=0.
  - It saturates at 16'hFFFF and resets to 0 on rst_f=0.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset: drive rst_f=0 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_src=0, in_ready=0000; release -> first grant on the next edge.
- Direct mode: mode=0, sel=2, ch2=32'hDEADBEEF valid, out_ready=1 -> in_ready=0100; next cycle out_data=DEADBEEF, out_src=2, out_valid=1. Set sel=3 with in_valid[3]=0 -> out_valid drops to 0 on the next edge.
- Round-robin fairness: mode=1, all 4 channels continuously valid with data k+1, out_ready=1 -> out_src sequence 0,1,2,3,0,1 and out_data 1,2,3,4,1,2 at one item per cycle.
- Backpressure: out_valid=1 holding 32'h00000005, out_ready=0 for 5 cycles -> out_data stable, in_ready=0000; with the macro defined, stall_cnt=5. Raise out_ready -> the pending grant loads in the same cycle.
- Skip and wrap: mode=1, rr_ptr=3, only ch1 valid -> g=1, rr_ptr becomes 2. Then only ch0 valid -> g=0 (wrap search 2,3,0).
- Mid-operation reset: assert rst_f=0 while out_valid=1 and out_ready=0 -> next edge out_valid=0, rr_ptr=0; the item is dropped and stall_cnt=0.
